// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register with bubble injection on jumps, stall hold and sticky halt.
// A long jump arms SHADOW extra bubble slots after the jump edge itself.
module fd_pipe_reg #(
    parameter int              PC_W     = 32,
    parameter int              INS_W    = 32,
    parameter logic [INS_W-1:0] NOP_WORD = INS_W'(32'hdc000000),
    parameter logic [5:0]      HALT_OP  = 6'b111111,
    parameter int              SHADOW   = 2,
    parameter int              CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             stall,
    input  logic [5:0]       op_d,
    input  logic [1:0]       jon_d,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [INS_W-1:0] ins_in,
    output logic [PC_W-1:0]  pc_out,
    output logic [INS_W-1:0] ins_out,
    output logic             valid_out,
    output logic             halted,
    output logic [CNT_W-1:0] shadow_cnt
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [INS_W-1:0] ins_q, ins_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             kill;

    assign kill = (jon_d != 2'b00) || (shadow_q != '0);

    always_comb begin
        pc_d     = pc_q;
        ins_d    = ins_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        shadow_d = shadow_q;
        // Once halted nothing moves; a halt opcode freezes data and counter on the same edge.
        if (!halted_q) begin
            if (op_d == HALT_OP) begin
                halted_d = 1'b1;
            end else begin
                if (kill) begin
                    ins_d   = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = pc_in;
                    ins_d   = ins_in;
                    valid_d = 1'b1;
                end
                // Shadow slots are time-based, so they drain even while stalled.
                if (jon_d[1]) begin
                    shadow_d = CNT_W'(SHADOW);
                end else if (shadow_q != '0) begin
                    shadow_d = shadow_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            pc_q     <= '0;
            ins_q    <= NOP_WORD;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            shadow_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ins_q    <= ins_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            shadow_q <= shadow_d;
        end
    end

    assign pc_out     = pc_q;
    assign ins_out    = ins_q;
    assign valid_out  = valid_q;
    assign halted     = halted_q;
    assign shadow_cnt = shadow_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: default instance (SHADOW=2, 32-bit) and a
// narrow instance (SHADOW=5, INS_W=16, NOP=0) with hand-computed expectations.
module tb_fd_pipe_reg;

    logic        clk = 1'b0;
    int          total = 0;
    int          bad = 0;

    // default instance
    logic        rstd, stall;
    logic [5:0]  op_d;
    logic [1:0]  jon_d;
    logic [31:0] pc_in, ins_in, pc_out, ins_out;
    logic        valid_out, halted;
    logic [3:0]  shadow_cnt;

    // narrow instance
    logic        s_rstd, s_stall;
    logic [5:0]  s_op_d;
    logic [1:0]  s_jon_d;
    logic [31:0] s_pc_in, s_pc_out;
    logic [15:0] s_ins_in, s_ins_out;
    logic        s_valid_out, s_halted;
    logic [3:0]  s_shadow_cnt;

    localparam logic [31:0] NOP = 32'hdc000000;

    always #5 clk = ~clk;

    fd_pipe_reg u_dut (
        .clk(clk), .rstd(rstd), .stall(stall), .op_d(op_d), .jon_d(jon_d),
        .pc_in(pc_in), .ins_in(ins_in), .pc_out(pc_out), .ins_out(ins_out),
        .valid_out(valid_out), .halted(halted), .shadow_cnt(shadow_cnt)
    );

    fd_pipe_reg #(
        .PC_W(32), .INS_W(16), .NOP_WORD(16'h0000), .SHADOW(5), .CNT_W(4)
    ) u_small (
        .clk(clk), .rstd(s_rstd), .stall(s_stall), .op_d(s_op_d), .jon_d(s_jon_d),
        .pc_in(s_pc_in), .ins_in(s_ins_in), .pc_out(s_pc_out), .ins_out(s_ins_out),
        .valid_out(s_valid_out), .halted(s_halted), .shadow_cnt(s_shadow_cnt)
    );

    task automatic applyStimulus(input logic rst, input logic stl, input logic [5:0] op,
                                 input logic [1:0] jon, input logic [31:0] pc,
                                 input logic [31:0] ins);
        rstd   = rst;
        stall  = stl;
        op_d   = op;
        jon_d  = jon;
        pc_in  = pc;
        ins_in = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] pc_e, input logic [31:0] ins_e,
                               input logic v_e, input logic h_e, input logic [3:0] c_e);
        total++;
        assert (pc_out === pc_e) else begin
            bad++;
            $error("[TB] FAIL %s pc_out got=%h exp=%h", tag, pc_out, pc_e);
        end
        total++;
        assert (ins_out === ins_e) else begin
            bad++;
            $error("[TB] FAIL %s ins_out got=%h exp=%h", tag, ins_out, ins_e);
        end
        total++;
        assert (valid_out === v_e) else begin
            bad++;
            $error("[TB] FAIL %s valid_out got=%b exp=%b", tag, valid_out, v_e);
        end
        total++;
        assert (halted === h_e) else begin
            bad++;
            $error("[TB] FAIL %s halted got=%b exp=%b", tag, halted, h_e);
        end
        total++;
        assert (shadow_cnt === c_e) else begin
            bad++;
            $error("[TB] FAIL %s shadow_cnt got=%0d exp=%0d", tag, shadow_cnt, c_e);
        end
    endtask

    task automatic applySmallStimulus(input logic rst, input logic [1:0] jon,
                                      input logic [31:0] pc, input logic [15:0] ins);
        s_rstd   = rst;
        s_jon_d  = jon;
        s_pc_in  = pc;
        s_ins_in = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic checkSmallOutput(input string tag, input logic [31:0] pc_e, input logic [15:0] ins_e,
                                    input logic v_e, input logic [3:0] c_e);
        total++;
        assert (s_pc_out === pc_e) else begin
            bad++;
            $error("[TB] FAIL %s pc_out got=%h exp=%h", tag, s_pc_out, pc_e);
        end
        total++;
        assert (s_ins_out === ins_e) else begin
            bad++;
            $error("[TB] FAIL %s ins_out got=%h exp=%h", tag, s_ins_out, ins_e);
        end
        total++;
        assert (s_valid_out === v_e) else begin
            bad++;
            $error("[TB] FAIL %s valid_out got=%b exp=%b", tag, s_valid_out, v_e);
        end
        total++;
        assert (s_shadow_cnt === c_e) else begin
            bad++;
            $error("[TB] FAIL %s shadow_cnt got=%0d exp=%0d", tag, s_shadow_cnt, c_e);
        end
    endtask

    initial begin
        s_rstd = 1'b1; s_stall = 1'b0; s_op_d = 6'h00; s_jon_d = 2'b00;
        s_pc_in = '0; s_ins_in = '0;

        // reset and straight-line fetch
        applyStimulus(1'b1, 1'b0, 6'h00, 2'b00, 32'h0, 32'h0);
        checkOutput("reset", 32'h0, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h10, 32'h12345678);
        checkOutput("fetch0", 32'h10, 32'h12345678, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h14, 32'h9abcdef0);
        checkOutput("fetch1", 32'h14, 32'h9abcdef0, 1'b1, 1'b0, 4'd0);

        // long jump: three NOP edges then a load
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b10, 32'h18, 32'h11111111);
        checkOutput("ljmp_e0", 32'h14, NOP, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h1c, 32'h22222222);
        checkOutput("ljmp_e1", 32'h14, NOP, 1'b0, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h20, 32'h33333333);
        checkOutput("ljmp_e2", 32'h14, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h24, 32'h44444444);
        checkOutput("ljmp_load", 32'h24, 32'h44444444, 1'b1, 1'b0, 4'd0);

        // short jump (11 also counts as long, 01 only kills one edge)
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b01, 32'h28, 32'h55555555);
        checkOutput("sjmp_nop", 32'h24, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h2c, 32'h66666666);
        checkOutput("sjmp_load", 32'h2c, 32'h66666666, 1'b1, 1'b0, 4'd0);

        // stall holds while inputs change
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h30, 32'haaaa0001);
        checkOutput("stall0", 32'h2c, 32'h66666666, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h34, 32'haaaa0002);
        checkOutput("stall1", 32'h2c, 32'h66666666, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h38, 32'haaaa0003);
        checkOutput("stall2", 32'h2c, 32'h66666666, 1'b1, 1'b0, 4'd0);

        // stall with long jump (bit1|bit0 = 11): squash wins, counter drains under stall
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b11, 32'h3c, 32'hbbbb0001);
        checkOutput("stjmp_e0", 32'h2c, NOP, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h3c, 32'hbbbb0002);
        checkOutput("stjmp_e1", 32'h2c, NOP, 1'b0, 1'b0, 4'd1);
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h3c, 32'hbbbb0003);
        checkOutput("stjmp_e2", 32'h2c, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 6'h00, 2'b00, 32'h3c, 32'hbbbb0004);
        checkOutput("stjmp_hold", 32'h2c, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h40, 32'h77777777);
        checkOutput("resume", 32'h40, 32'h77777777, 1'b1, 1'b0, 4'd0);

        // halt coinciding with a long jump: halt wins, counter not loaded
        applyStimulus(1'b0, 1'b0, 6'h3f, 2'b10, 32'h44, 32'h88888888);
        checkOutput("halt_set", 32'h40, 32'h77777777, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'($urandom), 6'($urandom), 2'($urandom), $urandom, $urandom);
            checkOutput("halt_frozen", 32'h40, 32'h77777777, 1'b1, 1'b1, 4'd0);
        end
        applyStimulus(1'b1, 1'b1, 6'h3f, 2'b11, 32'hffff, 32'hffffffff);
        checkOutput("halt_reset", 32'h0, NOP, 1'b0, 1'b0, 4'd0);

        // reset in the middle of a shadow
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h50, 32'hcccc0000);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b10, 32'h54, 32'hcccc0001);
        checkOutput("mid_arm", 32'h50, NOP, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 1'b0, 6'h00, 2'b00, 32'h58, 32'hcccc0002);
        checkOutput("mid_reset", 32'h0, NOP, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b0, 6'h00, 2'b00, 32'h5c, 32'hcccc0003);
        checkOutput("post_reset", 32'h5c, 32'hcccc0003, 1'b1, 1'b0, 4'd0);

        // narrow instance: SHADOW=5 gives six NOP edges
        applySmallStimulus(1'b1, 2'b00, 32'h0, 16'h0);
        checkSmallOutput("s_reset", 32'h0, 16'h0000, 1'b0, 4'd0);
        applySmallStimulus(1'b0, 2'b00, 32'h100, 16'hbeef);
        checkSmallOutput("s_load", 32'h100, 16'hbeef, 1'b1, 4'd0);
        applySmallStimulus(1'b0, 2'b10, 32'h104, 16'h1111);
        checkSmallOutput("s_jmp0", 32'h100, 16'h0000, 1'b0, 4'd5);
        for (int i = 4; i >= 0; i--) begin
            applySmallStimulus(1'b0, 2'b00, 32'h108, 16'h2222);
            checkSmallOutput("s_shadow", 32'h100, 16'h0000, 1'b0, 4'(i));
        end
        applySmallStimulus(1'b0, 2'b00, 32'h10c, 16'h3333);
        checkSmallOutput("s_load2", 32'h10c, 16'h3333, 1'b1, 4'd0);

        // reload at shadow_cnt=3 restarts the count at 5
        applySmallStimulus(1'b0, 2'b10, 32'h110, 16'h4444);
        checkSmallOutput("s_arm", 32'h10c, 16'h0000, 1'b0, 4'd5);
        applySmallStimulus(1'b0, 2'b00, 32'h114, 16'h5555);
        checkSmallOutput("s_cnt4", 32'h10c, 16'h0000, 1'b0, 4'd4);
        applySmallStimulus(1'b0, 2'b00, 32'h118, 16'h6666);
        checkSmallOutput("s_cnt3", 32'h10c, 16'h0000, 1'b0, 4'd3);
        applySmallStimulus(1'b0, 2'b10, 32'h11c, 16'h7777);
        checkSmallOutput("s_reload", 32'h10c, 16'h0000, 1'b0, 4'd5);
        for (int i = 4; i >= 0; i--) begin
            applySmallStimulus(1'b0, 2'b00, 32'h120, 16'h8888);
            checkSmallOutput("s_drain", 32'h10c, 16'h0000, 1'b0, 4'(i));
        end
        applySmallStimulus(1'b0, 2'b00, 32'h124, 16'h9999);
        checkSmallOutput("s_load3", 32'h124, 16'h9999, 1'b1, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
